// File: rtl/prio_arbiter_8.sv
// rtl/prio_arbiter_8.sv - 8-way registered-grant arbiter with hold timeout; PRIO_ARB_ROUND_ROBIN_EN selects round-robin search
module prio_arbiter_8 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam bit               TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_MAX   = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(MAX_HOLD - 1);

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    logic [7:0]       mask;

    logic [7:0]       eff;
    logic             win_any;
    logic [2:0]       win_idx;
    logic             owner_req;
    logic             timeout_hit;

    assign eff         = req & ~mask;
    assign owner_req   = req[gnt_idx];
    assign timeout_hit = TIMEOUT_EN && owner_req && (hold_cnt == HOLD_LAST);

`ifdef PRIO_ARB_ROUND_ROBIN_EN
    logic [2:0] last_idx;
    logic [2:0] cand;

    // Search begins one past the previous winner and wraps; first hit wins.
    always_comb begin
        win_any = 1'b0;
        win_idx = 3'd0;
        cand    = 3'd0;
        for (int k = 0; k < 8; k++) begin
            cand = last_idx + 3'(k) + 3'd1;
            if (!win_any && eff[cand]) begin
                win_any = 1'b1;
                win_idx = cand;
            end
        end
    end
`else
    // Ascending scan so the highest set bit is the last one written.
    always_comb begin
        win_any = 1'b0;
        win_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (eff[i]) begin
                win_any = 1'b1;
                win_idx = 3'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= 8'h00;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            hold_cnt  <= '0;
            mask      <= 8'h00;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
            last_idx  <= 3'd7;
`endif
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    mask     <= 8'h00;
                    hold_cnt <= '0;
                    if (win_any) begin
                        state     <= BUSY;
                        gnt       <= 8'd1 << win_idx;
                        gnt_idx   <= win_idx;
                        gnt_valid <= 1'b1;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
                        last_idx  <= win_idx;
`endif
                    end
                end
                BUSY: begin
                    if (hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                    // Release takes precedence over a coincident timeout.
                    if (!owner_req) begin
                        state     <= IDLE;
                        gnt       <= 8'h00;
                        gnt_valid <= 1'b0;
                    end else if (timeout_hit) begin
                        state     <= IDLE;
                        gnt       <= 8'h00;
                        gnt_valid <= 1'b0;
                        timeout   <= 1'b1;
                        mask      <= 8'd1 << gnt_idx;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prio_arbiter_8.sv
// tb/tb_prio_arbiter_8.sv - directed and random checks of prio_arbiter_8 against a behavioural model
module tb_prio_arbiter_8;

    localparam int MH = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_cmp;
    int n_err;

    // Behavioural model: who owns, for how many cycles, who is barred next arbitration.
    int m_owner;
    int m_held;
    int m_mask_idx;
    int m_last;
    int m_idx;
    bit m_to;

    prio_arbiter_8 #(.MAX_HOLD(MH), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner    = -1;
        m_held     = 0;
        m_mask_idx = -1;
        m_last     = 7;
        m_idx      = 0;
        m_to       = 1'b0;
    endtask

    function automatic int pick(input logic [7:0] r);
        int w;
        w = -1;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= 8; k++) begin
            int i;
            i = (m_last + k) % 8;
            if (w < 0 && r[i] && i != m_mask_idx) w = i;
        end
`else
        for (int i = 7; i >= 0; i--) begin
            if (w < 0 && r[i] && i != m_mask_idx) w = i;
        end
`endif
        return w;
    endfunction

    task automatic model_edge(input logic [7:0] r);
        int w;
        m_to = 1'b0;
        if (m_owner < 0) begin
            w = pick(r);
            m_mask_idx = -1;
            if (w >= 0) begin
                m_owner = w;
                m_held  = 0;
                m_idx   = w;
                m_last  = w;
            end
        end else begin
            m_held++;
            if (!r[m_owner]) begin
                m_owner = -1;
            end else if (MH != 0 && m_held == MH) begin
                m_mask_idx = m_owner;
                m_owner    = -1;
                m_to       = 1'b1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [7:0] eg;
        eg = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
        chk("gnt", gnt, eg);
        chk("gnt_idx", {5'd0, gnt_idx}, 8'(m_idx));
        chk("gnt_valid", {7'd0, gnt_valid}, {7'd0, (m_owner >= 0)});
        chk("timeout", {7'd0, timeout}, {7'd0, m_to});
        chk("onehot0", {7'd0, $onehot0(gnt)}, 8'd1);
    endtask

    task automatic cycle(input logic [7:0] r);
        req = r;
        @(posedge clk);
        model_edge(r);
        @(negedge clk);
        check_all();
    endtask

    task automatic async_reset(input logic [7:0] r);
        @(negedge clk);
        req = r;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        req   = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Reset asserted mid-cycle with every requester active.
        async_reset(8'hFF);
        cycle(8'hFF);
        chk("post_reset_valid", {7'd0, gnt_valid}, 8'd1);
        cycle(8'h00);
        cycle(8'h00);

`ifndef PRIO_ARB_ROUND_ROBIN_EN
        // Fixed priority then dead cycle then next winner.
        cycle(8'h25);
        chk("fixed_gnt5", gnt, 8'h20);
        chk("fixed_idx5", {5'd0, gnt_idx}, 8'd5);
        cycle(8'h05);
        chk("release_gnt", gnt, 8'h00);
        cycle(8'h05);
        chk("fixed_gnt2", gnt, 8'h04);
        chk("fixed_idx2", {5'd0, gnt_idx}, 8'd2);
        cycle(8'h00);
        cycle(8'h00);

        // No preemption by a higher index.
        cycle(8'h02);
        cycle(8'h82);
        chk("nopreempt_a", gnt, 8'h02);
        cycle(8'h82);
        chk("nopreempt_b", gnt, 8'h02);
        cycle(8'h80);
        chk("nopreempt_dead", gnt, 8'h00);
        cycle(8'h80);
        chk("nopreempt_idx7", {5'd0, gnt_idx}, 8'd7);
        cycle(8'h00);
        cycle(8'h00);

        // Timeout, masked re-arbitration, then owner regranted.
        cycle(8'h81);
        chk("to_first", gnt, 8'h80);
        repeat (3) cycle(8'h81);
        chk("to_still", gnt, 8'h80);
        cycle(8'h81);
        chk("to_pulse", {7'd0, timeout}, 8'd1);
        chk("to_gnt0", gnt, 8'h00);
        cycle(8'h81);
        chk("to_next0", gnt, 8'h01);
        chk("to_pulse_clr", {7'd0, timeout}, 8'd0);
        cycle(8'h80);
        cycle(8'h80);
        chk("to_regrant7", gnt, 8'h80);
        cycle(8'h00);
        cycle(8'h00);
`endif

        // Release coinciding with the timeout edge: no pulse, no mask.
        cycle(8'h01);
        repeat (3) cycle(8'h01);
        cycle(8'h00);
        chk("coinc_no_to", {7'd0, timeout}, 8'd0);
        cycle(8'h01);
        chk("coinc_regrant", gnt, 8'h01);
        cycle(8'h00);
        cycle(8'h00);

        // Sole masked requester waits one extra cycle.
        repeat (5) cycle(8'h08);
        chk("mask_to", {7'd0, timeout}, 8'd1);
        cycle(8'h08);
        chk("mask_block", gnt, 8'h00);
        cycle(8'h08);
        chk("mask_win", gnt, 8'h08);
        cycle(8'h00);
        cycle(8'h00);

        // Reset while a grant is held drops it without a pulse.
        cycle(8'h10);
        cycle(8'h10);
        async_reset(8'h10);
        chk("midbusy_reset", {7'd0, timeout}, 8'd0);

`ifdef PRIO_ARB_ROUND_ROBIN_EN
        cycle(8'h00);
        for (int k = 0; k < 9; k++) begin
            cycle(8'hFF);
            chk("rr_idx", {5'd0, gnt_idx}, 8'(k % 8));
            cycle(~(8'd1 << (k % 8)));
            chk("rr_dead", gnt, 8'h00);
        end
        cycle(8'h00);
`endif

        // Random traffic, owners usually keep holding their bit.
        for (int n = 0; n < 400; n++) begin
            logic [7:0] r;
            r = 8'($urandom);
            if (m_owner >= 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
            cycle(r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/prio_arbiter_8.md
Name: prio_arbiter_8

Overview:
- Clocked arbiter that shares one downstream resource among 8 requesters.
- Selects one requester via an 8-to-3 priority search. Presents a registered one-hot grant plus its 3-bit encoded index.
- Holds the grant until the owner releases, or until a hold-timeout forces release.
- Sits in front of any single-owner datapath (shared bus, shared encoder output, shared memory port) in the encoder/decoder library.

Parameters:
- MAX_HOLD, 16, max consecutive BUSY cycles per grant; 0 disables timeout.
- CNT_W, 5, width of hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  8  request vector, bit i = requester i; level, held while owning
- gnt  output  8  registered one-hot grant; all-zero when idle
- gnt_idx  output  3  binary index of granted requester; valid only when gnt_valid=1
- gnt_valid  output  1  high while any grant is held (equals |gnt)
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD

Behaviour:
- Reset (async assert, sync deassert by system): state=IDLE, gnt=8'h00, gnt_idx=3'b000, gnt_valid=0, timeout=0, hold_cnt=0, mask=8'h00.
- States: IDLE, BUSY.
- IDLE:
  - Sample eff = req & ~mask at clock edge.
  - If eff != 0: winner = highest-index set bit (bit 7 highest priority). Next cycle: gnt=1<<winner, gnt_idx=winner, gnt_valid=1, state=BUSY, hold_cnt=0, mask cleared.
  - If eff == 0: remain IDLE, outputs zero, mask cleared.
- Grant latency: 1 cycle from req sampled in IDLE to gnt asserted.
- BUSY:
  - Each edge, hold_cnt increments (saturating at MAX_HOLD).
  - Release: req[gnt_idx]==0 at edge -> next cycle gnt=0, gnt_valid=0, state=IDLE, timeout=0.
  - Timeout: only when MAX_HOLD!=0. If req[gnt_idx]==1 and hold_cnt==MAX_HOLD-1 at edge -> next cycle gnt=0, gnt_valid=0, timeout=1 for exactly one cycle, state=IDLE, mask=1<<gnt_idx.
  - If release and timeout coincide at the same edge, release wins: timeout=0, mask=0.
- Re-arbitration:
  - Exactly one dead (idle) cycle between consecutive grants. No back-to-back grant.
  - mask applies to the single IDLE arbitration that follows a timeout only, then clears.
  - If the masked requester is the only one requesting, no grant that cycle; it wins on the next.
- Requests from non-owners during BUSY are ignored; no preemption, even by higher priority.
- gnt_idx holds its last value when gnt_valid=0; consumers must qualify with gnt_valid.
- Multiple requesters in IDLE: highest-index wins; lower ones wait, no starvation guarantee in fixed mode.
- Reset mid-BUSY: immediate return to reset values; in-flight grant dropped without timeout pulse.
- gnt is always one-hot or zero; gnt_valid == |gnt every cycle.

Optional Feature:
- Macro: PRIO_ARB_ROUND_ROBIN_EN.
- Defined: round-robin priority. Stores last_idx (reset 3'b111). Search in IDLE starts at last_idx+1 (mod 8) and ascends with wrap; first set bit of eff wins; last_idx updates on every grant. Timeout mask still applies.
- Undefined: fixed priority as above; no last_idx register.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with req=8'hFF -> gnt=8'h00, gnt_valid=0, timeout=0 immediately; after release, grant on cycle 2.
- Fixed priority: req=8'b0010_0101 in IDLE -> next cycle gnt=8'b0010_0000, gnt_idx=5. Drop req[5] -> gnt=0 next cycle. One dead cycle, then gnt=8'b0000_0100, gnt_idx=2.
- No preemption: owner idx=1 holding; assert req[7] -> gnt stays 8'h02 until req[1] drops; then idle cycle, then gnt_idx=7.
- Timeout: MAX_HOLD=4, req=8'h81 held -> idx 7 granted 4 cycles, then gnt=0 with timeout=1 for one cycle. Next grant goes to idx 0; after idx 0 releases, idx 7 regranted.
- Coincident: MAX_HOLD=4, owner drops req on the 4th BUSY edge -> timeout stays 0; owner eligible at next arbitration.
- PRIO_ARB_ROUND_ROBIN_EN defined, req=8'hFF held with per-grant 1-cycle release -> gnt_idx sequence 0,1,2,…,7,0 with one idle cycle between grants.
